// File: rtl/apb_master_arbiter_if.sv
// Requester handshake plus APB master signals for apb_master_arbiter.
// The master modport is the arbiter side; the slave modport is the requester/APB-slave side.
interface apb_master_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          rsp_err;
  logic [ADDR_WIDTH-1:0]         PADDR;
  logic                          PSELx;
  logic                          PENABLE;
  logic                          PWRITE;
  logic [DATA_WIDTH-1:0]         PWDATA;
  logic                          PREADY;
  logic [DATA_WIDTH-1:0]         PRDATA;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, PREADY, PRDATA,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           PADDR, PSELx, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, PREADY, PRDATA,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           PADDR, PSELx, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port among NUM_REQ requesters,
// sequencing IDLE/SETUP/ACCESS with a PREADY wait-state timeout.
module apb_master_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  apb_master_arbiter_if.master bus
);

  localparam int GW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [GW-1:0]    LAST_RST = GW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         last_q, last_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0]    rvld_q, rvld_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  any_req;
  logic [GW-1:0]         gnt;
  int                    cand;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [GW-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Search upward from the requester after the last grant, wrapping at NUM_REQ.
  always_comb begin
    any_req = 1'b0;
    gnt     = last_q;
    cand    = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(last_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!any_req && bus.req_valid[cand[GW-1:0]]) begin
        any_req = 1'b1;
        gnt     = cand[GW-1:0];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state_q == IDLE && any_req && !PRESET) bus.req_ready = onehot(gnt);
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rvld_d    = '0;
    rdata_d   = '0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d   = SETUP;
          last_d    = gnt;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          paddr_d   = bus.req_addr[int'(gnt)*ADDR_WIDTH +: ADDR_WIDTH];
          pwrite_d  = bus.req_write[gnt];
          pwdata_d  = bus.req_write[gnt] ? bus.req_wdata[int'(gnt)*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        // PREADY is checked first so a completion on the timeout cycle is not aborted.
        if (bus.PREADY) begin
          state_d   = IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          rvld_d    = onehot(last_q);
          rdata_d   = pwrite_q ? '0 : bus.PRDATA;
        end else if (TIMEOUT > 0 && cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          rvld_d    = onehot(last_q);
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      last_q    <= LAST_RST;
      cnt_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rvld_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rvld_q    <= rvld_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign bus.PADDR     = paddr_q;
  assign bus.PSELx     = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.rsp_valid = rvld_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: directed scenarios plus random traffic
// against a transaction-level model (accept cycle + wait count -> whole transfer timeline).
module tb_apb_master_arbiter;
  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic PCLK = 1'b0;
  logic PRESET;

  apb_master_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_master_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .bus   (bus)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_err = 0;

  // requester-side pending requests
  bit            pend  [NR];
  logic          wr_q  [NR];
  logic [AW-1:0] addr_q[NR];
  logic [DW-1:0] wd_q  [NR];
  int            gen_pct = 0;

  // transfer model
  int            cyc = 0;
  bit            busy = 0;
  int            a_cyc = 0, rsp_cyc = 0, w_cur = 0, g_cur = 0, last_g = NR - 1;
  bit            err_cur = 0;
  logic [AW-1:0] m_paddr;
  logic          m_pwrite;
  logic [DW-1:0] m_pwdata;
  logic [DW-1:0] cap_rdata = '0;
  int            wait_fix = 0;
  bit            prd_fix_en = 0;
  logic [DW-1:0] prd_fix = '0;
  int            acc_log[$];
  int            acc_cyc[$];
  logic [DW-1:0] last_rd;
  logic          last_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit pend_any();
    bit a = 0;
    for (int i = 0; i < NR; i++) a |= pend[i];
    return a;
  endfunction

  function automatic int rr_pick();
    for (int k = 1; k <= NR; k++) begin
      int idx = (last_g + k) % NR;
      if (pend[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int pick_wait();
    int r;
    if (wait_fix >= 0) return wait_fix;
    r = $urandom_range(0, 9);
    if (r < 7) return $urandom_range(0, 3);
    if (r == 7) return TO - 1;
    if (r == 8) return TO;
    return $urandom_range(TO + 1, TO + 4);
  endfunction

  task automatic post(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[i] = 1'b1; wr_q[i] = wr; addr_q[i] = a; wd_q[i] = d;
  endtask

  // One cycle, entered just after a falling edge.
  task automatic step_body();
    logic [NR-1:0] exp_rv, exp_rdy;
    logic          exp_psel, exp_pen, exp_err;
    logic [DW-1:0] exp_rd, prd;
    int            g;
    cyc++;
    exp_psel = busy && cyc >= a_cyc + 1 && cyc < rsp_cyc;
    exp_pen  = busy && cyc >= a_cyc + 2 && cyc < rsp_cyc;
    exp_rv   = '0; exp_err = 1'b0; exp_rd = '0;
    if (busy && cyc == rsp_cyc) begin
      exp_rv[g_cur] = 1'b1;
      exp_err       = err_cur;
      exp_rd        = (err_cur || m_pwrite) ? '0 : cap_rdata;
      last_rd       = bus.rsp_rdata;
      last_err      = bus.rsp_err;
      busy          = 0;
    end
    chk("PSELx", bus.PSELx, exp_psel);
    chk("PENABLE", bus.PENABLE, exp_pen);
    chk("rsp_valid", bus.rsp_valid, exp_rv);
    chk("rsp_err", bus.rsp_err, exp_err);
    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
    if (exp_psel) begin
      chk("PADDR", bus.PADDR, m_paddr);
      chk("PWRITE", bus.PWRITE, m_pwrite);
      chk("PWDATA", bus.PWDATA, m_pwdata);
    end
    for (int i = 0; i < NR; i++)
      if (!pend[i] && gen_pct > 0 && $urandom_range(0, 99) < gen_pct)
        post(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]            = pend[i];
      bus.req_write[i]            = wr_q[i];
      bus.req_addr[i*AW +: AW]    = addr_q[i];
      bus.req_wdata[i*DW +: DW]   = wd_q[i];
    end
    exp_rdy = '0;
    if (!busy && pend_any()) begin
      g            = rr_pick();
      exp_rdy[g]   = 1'b1;
      busy         = 1;
      a_cyc        = cyc;
      g_cur        = g;
      last_g       = g;
      w_cur        = pick_wait();
      err_cur      = (TO > 0 && w_cur >= TO);
      rsp_cyc      = cyc + 3 + ((TO > 0 && w_cur > TO - 1) ? TO - 1 : w_cur);
      m_paddr      = addr_q[g];
      m_pwrite     = wr_q[g];
      m_pwdata     = wr_q[g] ? wd_q[g] : '0;
      pend[g]      = 1'b0;
      acc_log.push_back(g);
      acc_cyc.push_back(cyc);
    end
    if (busy && cyc >= a_cyc + 2) bus.PREADY = (cyc == a_cyc + 2 + w_cur);
    else                          bus.PREADY = 1'($urandom_range(0, 1));
    prd = prd_fix_en ? prd_fix : $urandom;
    bus.PRDATA = prd;
    if (busy && cyc == rsp_cyc - 1) cap_rdata = prd;
    #1;
    chk("req_ready", bus.req_ready, exp_rdy);
  endtask

  task automatic step();
    @(negedge PCLK);
    step_body();
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((busy || pend_any()) && n < maxc) begin
      step();
      n++;
    end
    chk("drain_bound", {62'd0, busy, pend_any()}, 64'd0);
  endtask

  initial begin
    int s;
    int n;
    int exp_ord[5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NR; i++) begin
      pend[i] = 0; wr_q[i] = 0; addr_q[i] = '0; wd_q[i] = '0;
    end
    bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.PREADY = 1'b0; bus.PRDATA = '0;
    PRESET = 1'b1;
    #12;
    chk("rst_PSELx", bus.PSELx, 0);
    chk("rst_PENABLE", bus.PENABLE, 0);
    chk("rst_PADDR", bus.PADDR, 0);
    chk("rst_PWDATA", bus.PWDATA, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    @(negedge PCLK);
    PRESET = 1'b0;

    // contention from reset: round-robin 0,1,2,3,0 every 3 cycles
    wait_fix = 0; gen_pct = 100;
    for (int i = 0; i < NR; i++) post(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
    s = acc_log.size();
    repeat (16) step();
    gen_pct = 0;
    drain(40);
    for (int k = 0; k < 5; k++) chk("rr_order", acc_log[s+k], exp_ord[k]);
    for (int k = 0; k < 4; k++) chk("rr_spacing", acc_cyc[s+k+1] - acc_cyc[s+k], 3);

    // single zero-wait write from requester 1
    post(1, 1'b1, 32'h10, 32'hA5A5_0001);
    s = acc_cyc.size();
    drain(20);
    chk("t1_grant", acc_log[s], 1);
    chk("t1_err", last_err, 0);
    chk("t1_rdata", last_rd, 0);

    // read with 3 wait states
    wait_fix = 3; prd_fix_en = 1; prd_fix = 32'hDEAD_BEEF;
    post(0, 1'b0, 32'h20, 32'h0);
    drain(20);
    chk("t2_rdata", last_rd, 32'hDEAD_BEEF);
    chk("t2_err", last_err, 0);
    prd_fix_en = 0;

    // timeout with PREADY held low, then a normal transfer
    wait_fix = 40;
    post(2, 1'b0, 32'h30, 32'h0);
    drain(40);
    chk("t4_err", last_err, 1);
    chk("t4_rdata", last_rd, 0);
    wait_fix = 0;
    post(3, 1'b1, 32'h34, 32'h0BAD_F00D);
    drain(20);
    chk("t4_next_err", last_err, 0);

    // PREADY rises on the last ACCESS cycle before timeout
    wait_fix = TO - 1; prd_fix_en = 1; prd_fix = 32'h1234_5678;
    post(1, 1'b0, 32'h44, 32'h0);
    drain(40);
    chk("t6_err", last_err, 0);
    chk("t6_rdata", last_rd, 32'h1234_5678);
    prd_fix_en = 0;

    // reset in the middle of ACCESS
    wait_fix = 10;
    post(1, 1'b1, 32'h50, 32'h1111_2222);
    n = 0;
    while (!(busy && cyc >= a_cyc + 3) && n < 30) begin
      step();
      n++;
    end
    chk("reach_access", bus.PENABLE, 1);
    post(0, 1'b0, 32'h60, 32'h0);
    post(2, 1'b1, 32'h64, 32'h3333_4444);
    post(3, 1'b0, 32'h68, 32'h0);
    #2 PRESET = 1'b1;
    #1;
    chk("mid_rst_PSELx", bus.PSELx, 0);
    chk("mid_rst_PENABLE", bus.PENABLE, 0);
    chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
    chk("mid_rst_req_ready", bus.req_ready, 0);
    @(posedge PCLK); #1;
    chk("mid_rst_hold_PSELx", bus.PSELx, 0);
    @(negedge PCLK);
    PRESET = 1'b0;
    busy = 0; last_g = NR - 1; wait_fix = 0;
    step_body();
    chk("rst_prio", acc_log[acc_log.size()-1], 0);
    drain(40);

    // random traffic
    wait_fix = -1; gen_pct = 30;
    repeat (600) step();
    gen_pct = 0;
    drain(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
Shares one APB master port among NUM_REQ local requesters and sequences every transfer through the APB IDLE/SETUP/ACCESS protocol.
- Arbitration is round-robin, one transfer at a time.
- Wait states are handled through PREADY; a programmable ACCESS timeout prevents bus lock-up.
- Sits between the requester logic and the APB interface signals (PADDR, PSELx, PENABLE, PWRITE, PWDATA, PREADY, PRDATA).

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, APB data width
TIMEOUT, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout

Ports:
PCLK  input  1  clock; all state updates on rising edge
PRESET  input  1  asynchronous active-high reset
req_valid  input  NUM_REQ  per-requester transfer request
req_write  input  NUM_REQ  per-requester direction, 1 = write
req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  input  NUM_REQ*DATA_WIDTH  packed write data, same packing
req_ready  output  NUM_REQ  one-hot accept strobe
rsp_valid  output  NUM_REQ  one-hot completion strobe, 1 cycle
rsp_rdata  output  DATA_WIDTH  read data, valid with rsp_valid
rsp_err  output  1  timeout abort flag, valid with rsp_valid
PADDR  output  ADDR_WIDTH  APB address
PSELx  output  1  APB select
PENABLE  output  1  APB enable
PWRITE  output  1  APB direction
PWDATA  output  DATA_WIDTH  APB write data
PREADY  input  1  APB slave ready
PRDATA  input  DATA_WIDTH  APB read data

Behaviour:
- Reset (asynchronous, immediate on PRESET=1):
  - FSM goes to IDLE; any in-flight transfer is dropped with no rsp_valid.
  - All outputs are 0.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, SETUP, ACCESS. All APB outputs and rsp_* are registered.
- IDLE:
  - If any req_valid is high, grant g = first set bit searching upward from last_grant+1, wrapping modulo NUM_REQ.
  - req_ready[g] is driven combinationally high in this cycle only.
  - At the edge: latch addr/write/wdata of g, set last_grant=g, PSELx=1, PENABLE=0, PADDR/PWRITE from g, PWDATA = wdata for writes and 0 for reads; go to SETUP.
  - With no request, stay in IDLE with PSELx=0, PENABLE=0.
- SETUP: exactly one cycle. Set PENABLE=1 and go to ACCESS. PREADY is ignored in SETUP.
- ACCESS: PADDR, PWRITE, PWDATA and PSELx are held stable.
  - PREADY=1 at the edge: PSELx=0, PENABLE=0, rsp_valid[g]=1 for one cycle, rsp_err=0. rsp_rdata = PRDATA for reads, 0 for writes. Go to IDLE.
  - PREADY=0: increment wait counter (width $clog2(TIMEOUT+1), cleared on entry to ACCESS).
  - TIMEOUT>0 and counter==TIMEOUT-1 with PREADY=0: abort. PSELx=0, PENABLE=0, rsp_valid[g]=1, rsp_err=1, rsp_rdata=0; go to IDLE.
  - PREADY=1 on the same edge as the timeout wins: normal completion.
- Latency:
  - Request sampled in IDLE to PSELx=1 is 1 cycle.
  - Zero-wait transfer: rsp_valid asserts 3 cycles after the accept cycle.
  - Back-to-back throughput is 1 transfer per 3 cycles minimum, because the IDLE cycle is always inserted.
- Requester contract:
  - Hold req_valid and payload until req_ready. req_valid may deassert before accept without effect.
  - A requester may present its next request during its own in-flight transfer; it is arbitrated at the next IDLE.
- Grant fairness: a requester that just completed has lowest priority at the next arbitration.
- rsp_valid and req_ready are never asserted for more than one requester in the same cycle.

Test Plan:
1. Single write: req 1 writes addr 0x10, data 0xA5A5_0001, PREADY tied 1.
   -> req_ready[1] asserts in cycle 0; PSELx=1/PENABLE=0 in cycle 1 and PENABLE=1 in cycle 2 with PADDR=0x10; rsp_valid[1] in cycle 3 with rsp_err=0.
2. Read with wait states: req 0 reads 0x20, PREADY low for 3 ACCESS cycles, then high with PRDATA=0xDEAD_BEEF.
   -> PADDR stable for the whole transfer; rsp_rdata=0xDEAD_BEEF with rsp_valid[0].
3. Contention: all 4 requesters hold req_valid continuously, PREADY=1.
   -> grant order 0,1,2,3,0; each rsp_valid one-hot; 3-cycle spacing between accepts.
4. Timeout: TIMEOUT=16, PREADY held 0.
   -> PSELx drops after 16 ACCESS cycles; rsp_valid with rsp_err=1 and rsp_rdata=0; next request is then serviced normally.
5. Reset mid-ACCESS: assert PRESET during ACCESS, between clock edges.
   -> PSELx, PENABLE and rsp_valid go to 0 immediately; no response for the dropped transfer; after release, requester 0 has priority.
6. Timeout/PREADY collision: PREADY=1 on exactly the 16th ACCESS cycle.
   -> normal completion with rsp_err=0 and PRDATA captured.
